fft_spectrum_sink: RTL
======================

FFT_SPECTRUM_SINK -- requirements
Module: fft_spectrum_sink

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1024, meaning FFT points per frame.
REQ-002 SHALL have parameter BIN_W, default 10, meaning bin index width (log2 FRAME_LEN).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning an FFT output beat is present.
REQ-006 SHALL have port in_sop, input, 1, meaning start of frame, qualified by in_valid.
REQ-007 SHALL have port in_eop, input, 1, meaning end of frame, qualified by in_valid.
REQ-008 SHALL have ports in_real and in_imag, input, 32 each, meaning signed FFT bin components.
REQ-009 SHALL have port in_ready, output, 1, meaning the sink accepts a beat; a beat transfers when in_valid && in_ready.
REQ-010 SHALL have ports mag_valid (1), mag_bin (BIN_W) and mag_out (32), outputs, meaning the per-bin magnitude-squared stream.
REQ-011 SHALL have ports res_valid (1), res_peak_bin (BIN_W), res_peak_mag (32) and res_err (1), outputs, meaning the per-frame result.
REQ-012 SHALL have port res_ready, input, 1, meaning the consumer accepts the result.
REQ-013 SHALL have port drop_cnt, output, 16, meaning the count of beats discarded outside a frame; it saturates at 0xFFFF.

Function
REQ-014 SHALL implement FSM states IDLE, FRAME, DRAIN and REPORT.
REQ-015 In IDLE, in_ready SHALL be 1; a transferred beat with in_sop SHALL be taken as bin 0 and move the FSM to FRAME; a transferred beat without in_sop SHALL be dropped and SHALL increment drop_cnt.
REQ-016 In FRAME, in_ready SHALL be 1 and each transferred beat SHALL increment the bin counter, which starts at 0.
REQ-017 A transferred beat carrying in_sop while in FRAME SHALL restart the frame: bin 0, peak cleared, sticky error flag set.
REQ-018 A transferred in_eop at bin FRAME_LEN-1 SHALL move the FSM to DRAIN with a good frame.
REQ-019 A transferred in_eop at a bin below FRAME_LEN-1, or a beat at bin FRAME_LEN-1 without in_eop, SHALL move the FSM to DRAIN with the error flag set.
REQ-020 If in_sop and in_eop arrive on the same beat in IDLE, the frame SHALL be treated as a 1-beat frame with the error flag set, unless FRAME_LEN is 1.
REQ-021 DRAIN SHALL hold in_ready at 0 for exactly 2 cycles while the magnitude pipeline empties, then move to REPORT.
REQ-022 In REPORT, res_valid SHALL be 1 with stable outputs and in_ready SHALL be 0; when res_valid && res_ready, the FSM SHALL return to IDLE on the next cycle and clear the peak and error flag.
REQ-023 The magnitude SHALL be computed as re = in_real[31:16] and im = in_imag[31:16], both signed; mag_out = re*re + im*im as a 32-bit unsigned value, which cannot overflow.
REQ-024 Magnitude latency SHALL be 2 cycles: mag_valid, mag_bin and mag_out SHALL follow the transferred beat by 2 cycles (register inputs, then register squares and sum).
REQ-025 Peak tracking SHALL use a strict greater-than comparison on pipeline output, so that on ties the lowest bin wins; an all-zero frame SHALL report bin 0 with mag 0.
REQ-026 Beats not transferred (in_ready=0) SHALL be ignored completely.

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE, and in_ready, mag_valid, res_valid and res_err SHALL be 0; mag_bin, mag_out, res_peak_bin, res_peak_mag and drop_cnt SHALL be 0, and the pipeline SHALL be flushed.
REQ-028 Reset asserted mid-frame or in REPORT SHALL abandon the frame with no res_valid; in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the default FRAME_LEN/BIN_W values and the 16-bit magnitude slice constants.
REQ-030 The 2-stage magnitude-squared datapath SHALL be one sub-module, fft_mag_sq, with a valid/bin sideband pipelined alongside the data.
REQ-031 The RTL SHALL be 120-400 lines in total.

Verification
REQ-032 Good frame, FRAME_LEN=8: bin k has real=(k<<16), imag=0 -> mag_out=k*k two cycles later; res_peak_bin=7, res_peak_mag=49, res_err=0.
REQ-033 Tie: bins 2 and 5 both have real=0x0003_0000 and all others 0 -> res_peak_bin=2, res_peak_mag=9.
REQ-034 Short frame, FRAME_LEN=8: eop at bin 4 -> res_err=1, in_ready=0 from DRAIN until the res_ready handshake.
REQ-035 3 beats with no sop in IDLE, then a good frame -> drop_cnt=3 and a correct result.
REQ-036 Backpressure: res_ready held 0 for 10 cycles -> res_valid and all result fields stay stable and in_ready=0; after res_ready=1 for one cycle -> IDLE with in_ready=1.
REQ-037 rst pulsed at bin 3 -> no res_valid; the next full frame reports correctly with res_err=0.

Source files
------------

// File: rtl/fft_spectrum_sink_pkg.sv
// Shared definitions for the FFT spectrum sink: FSM encoding, default frame geometry and
// the bit slice that feeds the magnitude-squared datapath.
package fft_spectrum_sink_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFrame  = 2'd1,
        StDrain  = 2'd2,
        StReport = 2'd3
    } sink_state_e;

    localparam int unsigned DefFrameLen = 1024;
    localparam int unsigned DefBinW     = 10;

    localparam int unsigned MagSliceHi = 31;
    localparam int unsigned MagSliceLo = 16;
    localparam int unsigned MagSliceW  = MagSliceHi - MagSliceLo + 1;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage magnitude-squared pipeline: stage 1 registers the signed upper halves,
// stage 2 registers re*re + im*im. The valid/bin sideband travels with the data.
module fft_mag_sq
    import fft_spectrum_sink_pkg::*;
#(
    parameter int unsigned BIN_W = DefBinW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [BIN_W-1:0] in_bin,
    input  logic [31:0]      in_real,
    input  logic [31:0]      in_imag,
    output logic             out_valid,
    output logic [BIN_W-1:0] out_bin,
    output logic [31:0]      out_mag
);

    logic                        v1_q;
    logic [BIN_W-1:0]            bin1_q;
    logic signed [MagSliceW-1:0] re_q;
    logic signed [MagSliceW-1:0] im_q;

    logic                        v2_q;
    logic [BIN_W-1:0]            bin2_q;
    logic [31:0]                 mag_q;

    logic signed [31:0]          re_x;
    logic signed [31:0]          im_x;
    logic signed [31:0]          re_sq;
    logic signed [31:0]          im_sq;
    logic [31:0]                 mag_d;

    // Worst case is (-2^15)^2 * 2 = 2^31, which fits the unsigned 32-bit sum.
    always_comb begin
        re_x  = 32'(re_q);
        im_x  = 32'(im_q);
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        mag_d = re_sq + im_sq;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            bin1_q <= '0;
            re_q   <= '0;
            im_q   <= '0;
            v2_q   <= 1'b0;
            bin2_q <= '0;
            mag_q  <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                bin1_q <= in_bin;
                re_q   <= in_real[MagSliceHi:MagSliceLo];
                im_q   <= in_imag[MagSliceHi:MagSliceLo];
            end
            v2_q <= v1_q;
            if (v1_q) begin
                bin2_q <= bin1_q;
                mag_q  <= mag_d;
            end
        end
    end

    assign out_valid = v2_q;
    assign out_bin   = bin2_q;
    assign out_mag   = mag_q;

endmodule

// File: rtl/fft_spectrum_sink.sv
// Consumes framed FFT output, streams per-bin magnitude squared and reports the peak bin
// of each frame together with a sticky framing-error flag.
module fft_spectrum_sink
    import fft_spectrum_sink_pkg::*;
#(
    parameter int unsigned FRAME_LEN = DefFrameLen,
    parameter int unsigned BIN_W     = DefBinW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [31:0]      in_real,
    input  logic [31:0]      in_imag,
    output logic             in_ready,
    output logic             mag_valid,
    output logic [BIN_W-1:0] mag_bin,
    output logic [31:0]      mag_out,
    output logic             res_valid,
    output logic [BIN_W-1:0] res_peak_bin,
    output logic [31:0]      res_peak_mag,
    output logic             res_err,
    input  logic             res_ready,
    output logic [15:0]      drop_cnt
);

    localparam logic [BIN_W-1:0] LastBin = BIN_W'(FRAME_LEN - 1);

    sink_state_e      state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             err_q, err_d;
    logic             drain_q, drain_d;
    logic [15:0]      drop_q, drop_d;
    logic [BIN_W-1:0] peak_bin_q, peak_bin_d;
    logic [31:0]      peak_mag_q, peak_mag_d;
    logic             in_ready_q;
    logic             res_valid_q;

    logic             accept;
    logic             beat_take;
    logic [BIN_W-1:0] beat_bin;
    logic             beat_last;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        err_d      = err_q;
        drain_d    = drain_q;
        drop_d     = drop_q;
        peak_bin_d = peak_bin_q;
        peak_mag_d = peak_mag_q;
        beat_take  = 1'b0;
        beat_bin   = '0;
        beat_last  = 1'b0;

        // Bin 0 always reseeds the peak, which also discards a restarted frame's old peak.
        if (mag_valid && ((mag_bin == '0) || (mag_out > peak_mag_q))) begin
            peak_bin_d = mag_bin;
            peak_mag_d = mag_out;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (in_sop) begin
                        beat_take = 1'b1;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            StFrame: begin
                if (accept) begin
                    beat_take = 1'b1;
                    if (in_sop) begin
                        err_d = 1'b1;
                    end else begin
                        beat_bin = bin_q;
                    end
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = StReport;
                end
            end
            StReport: begin
                if (res_valid_q && res_ready) begin
                    state_d    = StIdle;
                    err_d      = 1'b0;
                    peak_bin_d = '0;
                    peak_mag_d = '0;
                end
            end
        endcase

        if (beat_take) begin
            beat_last = (beat_bin == LastBin);
            if (in_eop || beat_last) begin
                state_d = StDrain;
                drain_d = 1'b0;
                if (!(in_eop && beat_last)) begin
                    err_d = 1'b1;
                end
            end else begin
                state_d = StFrame;
                bin_d   = beat_bin + BIN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bin_q       <= '0;
            err_q       <= 1'b0;
            drain_q     <= 1'b0;
            drop_q      <= '0;
            peak_bin_q  <= '0;
            peak_mag_q  <= '0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            err_q       <= err_d;
            drain_q     <= drain_d;
            drop_q      <= drop_d;
            peak_bin_q  <= peak_bin_d;
            peak_mag_q  <= peak_mag_d;
            in_ready_q  <= (state_d == StIdle) || (state_d == StFrame);
            res_valid_q <= (state_d == StReport);
        end
    end

    fft_mag_sq #(
        .BIN_W (BIN_W)
    ) u_mag_sq (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (beat_take),
        .in_bin    (beat_bin),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (mag_valid),
        .out_bin   (mag_bin),
        .out_mag   (mag_out)
    );

    assign in_ready     = in_ready_q;
    assign res_valid    = res_valid_q;
    assign res_peak_bin = peak_bin_q;
    assign res_peak_mag = peak_mag_q;
    assign res_err      = err_q;
    assign drop_cnt     = drop_q;

endmodule
